// File: rtl/aes_key_sched_seq.sv
// ---------------------------------------------------------------------------
// aes_key_sched_seq -- iterative AES-128 key-schedule engine
//
// Accepts one 128-bit cipher key and streams round keys rk0..rkNR, one per
// valid/ready handshake. Only the current round key is stored; each accepted
// round key triggers one key-expansion step to produce the next.
//
// Parameters
//   NR         number of expanded round keys after rk0 (1..10, 10 = AES-128)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   key_in     cipher key, bits [127:120] = byte 0 (FIPS-197 order)
//   key_valid  key_in valid
//   key_ready  engine idle and able to accept a key
//   rk_out     current round key, same byte order as key_in
//   rk_idx     index of rk_out, 0..NR
//   rk_valid   rk_out / rk_idx valid
//   rk_ready   consumer accepts rk_out
//   busy       high while a schedule is being emitted
//
// Build option
//   KEY_SCHED_ZEROIZE_EN  when defined, the key register and rcon are cleared
//                         on the final handshake so no key material remains
//                         in IDLE. Default: rkNR stays visible on rk_out.
// ---------------------------------------------------------------------------

// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    // Row-major table, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset 8*(255-n); ~byte_val is exactly 255-n.
    assign sub_val = SBOX_TABLE[{~byte_val, 3'b000} +: 8];
endmodule

module aes_key_sched_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t       state;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [3:0]   idx_reg;
    logic [7:0]   rcon;

    logic accept;
    logic handshake;
    logic last_key;

    assign accept    = key_valid && key_ready;
    assign handshake = rk_valid && rk_ready;
    assign last_key  = (idx_reg == LAST_IDX);

    // -----------------------------------------------------------------------
    // Key-expansion step: next round key from the current one and rcon
    // -----------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] key_next;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    // RotWord({a,b,c,d}) = {b,c,d,a}
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .byte_val (rot_w3[8*i +: 8]),
            .sub_val  (sub_w3[8*i +: 8])
        );
    end

    assign t        = sub_w3 ^ {rcon, 24'h000000};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state is always written with <= so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path driven, so no
    // latch is inferred when a branch does not mention state_next.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EMIT;
            EMIT:    if (handshake && last_key) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state, so glitch-free)
    // -----------------------------------------------------------------------
    always_comb begin
        key_ready = (state == IDLE);
        busy      = (state != IDLE);
        rk_valid  = (state == EMIT);
        rk_out    = key_reg;
        rk_idx    = idx_reg;
    end

    // -----------------------------------------------------------------------
    // Datapath: key register, round index, rcon
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            idx_reg <= '0;
            rcon    <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_reg <= key_in;
                        idx_reg <= '0;
                        rcon    <= 8'h01;
                    end
                end
                EMIT: begin
                    // A stall (no handshake) leaves every register untouched.
                    if (handshake) begin
                        if (!last_key) begin
                            key_reg <= key_next;
                            idx_reg <= idx_reg + 4'd1;
                            rcon    <= xtime(rcon);
                        end else begin
`ifdef KEY_SCHED_ZEROIZE_EN
                            // Scrub key material as the schedule completes.
                            key_reg <= '0;
                            rcon    <= 8'h00;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_seq -- scoreboard bench for aes_key_sched_seq
//
// A reference model (FIPS-197 word-wise key expansion with an S-box derived
// from GF(2^8) inversion plus the affine map) pushes the expected round-key
// stream when each key is issued; an independent monitor pops and compares
// on every rk_valid/rk_ready handshake and checks hold stability on stalls.
// Honours KEY_SCHED_ZEROIZE_EN for the idle-output expectation.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_seq;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic         busy;

    always #5 clk = ~clk;

    aes_key_sched_seq #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   sbox_t [256];
    logic [127:0] mrk  [0:NR];
    logic [127:0] seen [0:NR];
    logic [127:0] run1 [0:NR];

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;     // 0: rk_ready high, 1: random with forced stall
    int stall3_left = 0;
    int stall_at3 = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a ^= 8'h1B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_schedule(input logic [127:0] key);
        logic [31:0] w [0:4*(NR+1)-1];
        logic [31:0] temp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*(NR+1); i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]],
                        sbox_t[temp[15:8]], sbox_t[temp[7:0]]};
                temp ^= {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++)
            mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_key(input logic [127:0] k);
        compute_schedule(k);
        for (int r = 0; r <= NR; r++) exp_q.push_back({4'(r), mrk[r]});
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- rk_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                rk_ready = 1'b1;
            end else if (rk_valid && rk_idx == 4'd3 && stall3_left > 0) begin
                rk_ready = 1'b0;
                stall3_left--;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic         held_v = 1'b0;
        logic [127:0] held_out = '0;
        logic [3:0]   held_idx = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_rk_valid", rk_valid, 1'b1);
                    check("stall_rk_out", rk_out, held_out);
                    check("stall_rk_idx", rk_idx, held_idx);
                end
                held_v = 1'b0;
                if (rk_valid && rk_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_key: idx %0d key %h with empty queue",
                                 rk_idx, rk_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (rk_idx !== e.idx || rk_out !== e.key) begin
                            errors++;
                            $display("FAIL sb_round_key: got idx %0d %h, expected idx %0d %h",
                                     rk_idx, rk_out, e.idx, e.key);
                        end
                    end
                    if (!$isunknown(rk_idx) && rk_idx <= 4'(NR)) seen[rk_idx] = rk_out;
                end else if (rk_valid) begin
                    held_v   = 1'b1;
                    held_out = rk_out;
                    held_idx = rk_idx;
                    if (rk_idx == 4'd3) stall_at3++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_seen();
        for (int r = 0; r <= NR; r++) seen[r] = {128{1'bx}};
    endtask

    task automatic send_key(input logic [127:0] k);
        int n = 0;
        @(negedge clk);
        while (!key_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("FAIL send_key_timeout: key_ready stayed %b", key_ready);
            return;
        end
        key_in    = k;
        key_valid = 1'b1;
        push_key(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] ka, kb, kr;
        logic [127:0] idle_exp;
        int           cnt;
        int           n;
        bit           saw_ready, got_last;

        build_sbox();
        #22 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        check("reset_rk_valid", rk_valid, 1'b0);
        check("reset_rk_idx", rk_idx, 4'd0);
        check("reset_rk_out", rk_out, 128'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_key_ready", key_ready, 1'b1);

        // FIPS-197 key, no back-pressure
        ready_mode = 0;
        clear_seen();
        send_key(fips_key);
        check("fips_latency_valid", rk_valid, 1'b1);
        check("fips_latency_idx", rk_idx, 4'd0);
        check("fips_rk0", rk_out, fips_key);
        cnt = 1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!rk_valid) break;
            cnt++;
            n++;
        end
        check("fips_valid_run_length", cnt, 32'(NR + 1));
        check("fips_key_ready_after", key_ready, 1'b1);
        check("fips_rk1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEY_SCHED_ZEROIZE_EN
        idle_exp = 128'h0;
`else
        idle_exp = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
        check("idle_rk_out", rk_out, idle_exp);
        for (int r = 0; r <= NR; r++) run1[r] = seen[r];

        // Same key with random back-pressure and a 5-cycle stall at idx 3
        ready_mode  = 1;
        stall3_left = 5;
        stall_at3   = 0;
        clear_seen();
        send_key(fips_key);
        wait_idle();
        check("stall_idx3_cycles_ge5", 32'(stall_at3 >= 5), 32'd1);
        for (int r = 0; r <= NR; r++) check("stall_run_matches", seen[r], run1[r]);

        // key_valid held high with another key throughout EMIT
        ready_mode = 0;
        @(negedge clk);
        ka = rand_key();
        kb = rand_key();
        key_in    = ka;
        key_valid = 1'b1;
        push_key(ka);
        @(negedge clk);
        key_in    = kb;
        saw_ready = 1'b0;
        got_last  = 1'b0;
        n = 0;
        while (n < 100) begin
            if (key_ready) saw_ready = 1'b1;
            if (rk_valid && rk_ready && rk_idx == 4'(NR)) begin
                got_last = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("hold_key_ready_in_emit", saw_ready, 1'b0);
        check("hold_final_handshake", got_last, 1'b1);
        @(negedge clk);
        check("hold_bubble_rk_valid", rk_valid, 1'b0);
        check("hold_bubble_key_ready", key_ready, 1'b1);
        push_key(kb);
        @(negedge clk);
        key_valid = 1'b0;
        check("hold_second_rk_valid", rk_valid, 1'b1);
        check("hold_second_rk_idx", rk_idx, 4'd0);
        check("hold_second_rk0", rk_out, kb);
        wait_idle();

        // All-zero key
        ready_mode  = 1;
        stall3_left = 0;
        clear_seen();
        send_key(128'h0);
        wait_idle();
        check("zero_rk1", seen[1], 128'h62636363626363636263636362636363);
        check("zero_rk10", seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Asynchronous reset in the middle of a schedule
        ready_mode = 0;
        send_key(rand_key());
        n = 0;
        while (!(rk_valid && rk_idx == 4'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_idx5", rk_idx, 4'd5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_rk_valid", rk_valid, 1'b0);
        check("midreset_rk_idx", rk_idx, 4'd0);
        check("midreset_busy", busy, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("postreset_key_ready", key_ready, 1'b1);
        check("postreset_rk_out", rk_out, 128'h0);
        kr = rand_key();
        clear_seen();
        send_key(kr);
        check("postreset_rk0", rk_out, kr);
        wait_idle();
        check("postreset_rk1", seen[1], mrk[1]);

        // Random keys under random back-pressure
        ready_mode = 1;
        for (int k = 0; k < 4; k++) send_key(rand_key());
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
